// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: receive side of the multiplexed 7-segment display bus.
// Samples anode selects and active-low segment lines, accepts a digit once
// the bus has been stable for STABLE_CYC edges, decodes it back into a
// 4-bit value and tracks frame completion across all DIGITS positions.
// Optional macro SEG7_HEX_DECODE_EN: also recognise the A-F patterns.
module seg7_scan_reader #(
  parameter int DIGITS     = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_in,
  input  logic [7:0]            seg_in,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     valid_mask,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  frame_valid,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYC - 1);

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic [DIGITS+7:0]     r_s_q;
  logic [DIGITS-1:0]     r_seen;
  logic [4*DIGITS-1:0]   r_digits;
  logic [DIGITS-1:0]     r_dp;
  logic [DIGITS-1:0]     r_valid;
  logic [DIGITS-1:0]     r_blank;
  logic                  r_frame;
  logic                  r_err;

  logic [DIGITS-1:0]     w_sel;
  logic                  w_match;
  logic                  w_single;
  logic                  w_multi;
  logic                  w_dec_ok;
  logic                  w_blank;
  logic [3:0]            w_dec_val;
  logic [DIGITS-1:0]     w_seen_next;

  // Anode qualification: one-hot-low selects a position, multi-hot is an error
  always_comb begin
    w_sel       = ~an_in;
    w_match     = ({an_in, seg_in} == r_s_q);
    w_single    = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    w_multi     = (w_sel != '0) && !w_single;
    w_seen_next = r_seen | w_sel;
  end

  // Segment pattern decode for seg_in[6:0]
  always_comb begin
    w_dec_ok  = 1'b1;
    w_blank   = 1'b0;
    w_dec_val = 4'd0;
    case (seg_in[6:0])
      7'h40: w_dec_val = 4'd0;
      7'h79: w_dec_val = 4'd1;
      7'h24: w_dec_val = 4'd2;
      7'h30: w_dec_val = 4'd3;
      7'h19: w_dec_val = 4'd4;
      7'h12: w_dec_val = 4'd5;
      7'h02: w_dec_val = 4'd6;
      7'h78: w_dec_val = 4'd7;
      7'h00: w_dec_val = 4'd8;
      7'h10: w_dec_val = 4'd9;
`ifdef SEG7_HEX_DECODE_EN
      7'h08: w_dec_val = 4'd10;
      7'h03: w_dec_val = 4'd11;
      7'h46: w_dec_val = 4'd12;
      7'h21: w_dec_val = 4'd13;
      7'h06: w_dec_val = 4'd14;
      7'h0E: w_dec_val = 4'd15;
`endif
      7'h7F: begin
        w_dec_ok = 1'b0;
        w_blank  = 1'b1;
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Stability FSM, capture into per-position registers and frame tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_s_q    <= '1;
      r_seen   <= '0;
      r_digits <= '0;
      r_dp     <= '0;
      r_valid  <= '0;
      r_blank  <= '0;
      r_frame  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_s_q   <= {an_in, seg_in};
      r_frame <= 1'b0;
      r_err   <= 1'b0;
      if (!w_match) begin
        r_cnt   <= 8'd1;
        r_state <= w_single ? SETTLE : IDLE;
        if (w_multi) r_err <= 1'b1;
      end else begin
        case (r_state)
          SETTLE: begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == LAST_CNT) begin
              r_state <= HELD;
              for (int unsigned i = 0; i < DIGITS; i++) begin
                if (w_sel[i]) begin
                  r_dp[i] <= ~seg_in[7];
                  if (w_dec_ok) begin
                    r_digits[4*i +: 4] <= w_dec_val;
                    r_valid[i]         <= 1'b1;
                    r_blank[i]         <= 1'b0;
                  end else begin
                    r_valid[i] <= 1'b0;
                    r_blank[i] <= w_blank;
                  end
                end
              end
              if (!w_dec_ok && !w_blank) r_err <= 1'b1;
              if (w_seen_next == '1) begin
                r_frame <= 1'b1;
                r_seen  <= '0;
              end else begin
                r_seen <= w_seen_next;
              end
            end
          end
          HELD:    r_state <= HELD;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign digits      = r_digits;
  assign dp_out      = r_dp;
  assign valid_mask  = r_valid;
  assign blank_mask  = r_blank;
  assign frame_valid = r_frame;
  assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed testbench for seg7_scan_reader (DIGITS=8, STABLE_CYC=4).
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an_in;
  logic [7:0]  seg_in;
  logic [31:0] digits;
  logic [7:0]  dp_out;
  logic [7:0]  valid_mask;
  logic [7:0]  blank_mask;
  logic        frame_valid;
  logic        err;

  int total = 0;
  int bad   = 0;
  int fv_total  = 0;
  int err_total = 0;

  logic [7:0] segtab [8] = '{8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78, 8'h00};

  seg7_scan_reader #(.DIGITS(8), .STABLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .digits(digits), .dp_out(dp_out), .valid_mask(valid_mask),
    .blank_mask(blank_mask), .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle so each one-cycle pulse counts once
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_total++;
    if (err === 1'b1) err_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a bus value at the falling edge and hold it for n rising edges
  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
    @(negedge clk);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fv0;
  int e0;

  initial begin
    rst    = 1'b0;
    an_in  = 8'($urandom);
    seg_in = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digits", digits, 32'h0);
    chk("rst_masks", {dp_out, valid_mask, blank_mask}, 32'h0);
    chk("rst_pulses", {30'h0, frame_valid, err}, 32'h0);
    @(negedge clk);
    an_in  = 8'hFF;
    seg_in = 8'hFF;
    rst    = 1'b1;

    // Single digit: not yet accepted after 3 edges, accepted on the 4th
    hold(8'hFE, 8'hC0, 3);
    chk("single_early_valid", {24'h0, valid_mask}, 32'h0);
    hold(8'hFE, 8'hC0, 1);
    chk("single_valid", {24'h0, valid_mask}, 32'h01);
    chk("single_digit", {28'h0, digits[3:0]}, 32'h0);
    chk("single_dp", {24'h0, dp_out}, 32'h0);
    chk("single_err", {31'h0, err}, 32'h0);
    hold(8'hFF, 8'hFF, 2);

    // Glitch held only 3 edges never lands
    hold(8'hFD, 8'hF9, 3);
    hold(8'hFF, 8'hFF, 3);
    chk("glitch_valid", {24'h0, valid_mask}, 32'h01);
    chk("glitch_digits", digits, 32'h0);

    // Full frame "12345678"
    fv0 = fv_total;
    for (int p = 0; p < 8; p++) begin
      hold(~(8'h01 << p), segtab[p], 4);
      chk($sformatf("frame_fv_p%0d", p), {31'h0, frame_valid}, (p == 7) ? 32'h1 : 32'h0);
      hold(~(8'h01 << p), segtab[p], 2);
    end
    chk("frame_digits", digits, 32'h87654321);
    chk("frame_valid_mask", {24'h0, valid_mask}, 32'hFF);
    chk("frame_pulse_count", fv_total - fv0, 32'd1);
    hold(8'hFF, 8'hFF, 2);

    // Multi-hot anode: one err pulse, no capture
    e0 = err_total;
    hold(8'hFC, 8'hC0, 1);
    chk("multi_err_now", {31'h0, err}, 32'h1);
    hold(8'hFC, 8'hC0, 4);
    chk("multi_err_count", err_total - e0, 32'd1);
    chk("multi_digits", digits, 32'h87654321);

    // Blank with dp lit on position 2
    e0 = err_total;
    hold(8'hFB, 8'h7F, 4);
    chk("blank2_mask", {24'h0, blank_mask}, 32'h04);
    chk("blank2_dp", {31'h0, dp_out[2]}, 32'h1);
    // Blank with dp off on position 3
    hold(8'hF7, 8'hFF, 4);
    chk("blank3_mask", {24'h0, blank_mask}, 32'h0C);
    chk("blank3_dp", {31'h0, dp_out[3]}, 32'h0);
    chk("blank_no_err", err_total - e0, 32'd0);

    // Unrecognised pattern on position 4
    hold(8'hEF, 8'hAA, 4);
    chk("bad_err", {31'h0, err}, 32'h1);
    chk("bad_valid", {24'h0, valid_mask}, 32'hE3);
    chk("bad_blank", {24'h0, blank_mask}, 32'h0C);
    chk("bad_digits", digits, 32'h87654321);

    // Hex pattern A on position 0
    hold(8'hFE, 8'h88, 4);
`ifdef SEG7_HEX_DECODE_EN
    chk("hex_digit", {28'h0, digits[3:0]}, 32'hA);
    chk("hex_valid", {31'h0, valid_mask[0]}, 32'h1);
    chk("hex_err", {31'h0, err}, 32'h0);
`else
    chk("hex_digit", {28'h0, digits[3:0]}, 32'h1);
    chk("hex_valid", {31'h0, valid_mask[0]}, 32'h0);
    chk("hex_err", {31'h0, err}, 32'h1);
`endif

    // Partial frame then reset mid-dwell
    for (int p = 0; p < 4; p++) hold(~(8'h01 << p), 8'hC0, 6);
    hold(8'hEF, 8'hC0, 2);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_digits", digits, 32'h0);
    chk("rst2_masks", {dp_out, valid_mask, blank_mask}, 32'h0);
    @(negedge clk);
    an_in  = 8'hFF;
    seg_in = 8'hFF;
    rst    = 1'b1;

    // Descending scan: a stale seen mask would complete the frame early
    fv0 = fv_total;
    for (int p = 7; p >= 0; p--) begin
      hold(~(8'h01 << p), segtab[p], 4);
      chk($sformatf("rescan_fv_p%0d", p), {31'h0, frame_valid}, (p == 0) ? 32'h1 : 32'h0);
      hold(~(8'h01 << p), segtab[p], 2);
    end
    chk("rescan_pulse_count", fv_total - fv0, 32'd1);
    chk("rescan_digits", digits, 32'h87654321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
